// File: rtl/axi_ram_ctrl.sv
// axi_ram_ctrl: AXI4-Lite slave that turns AW/W and AR transactions into single-cycle RAM strobes.
// Optional `AXI_RAM_CTRL_SLVERR_EN: misaligned byte addresses get SLVERR and never reach the RAM.
module axi_ram_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH/8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [STRB_WIDTH-1:0] mem_be,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                  mem_rd,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_cs
);
  localparam int LSB = $clog2(STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LSB_MASK = ADDR_WIDTH'(STRB_WIDTH-1);

  typedef enum logic [2:0] {W_IDLE, W_WAIT_W, W_WAIT_AW, W_MEM, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_CAP, R_DATA} rstate_t;

  wstate_t               r_wstate, w_wnext;
  rstate_t               r_rstate, w_rnext;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_wmis, r_rmis;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  w_aw_hs, w_w_hs, w_ar_hs, w_aw_mis, w_ar_mis;

`ifdef AXI_RAM_CTRL_SLVERR_EN
  assign w_aw_mis = (s_axi_awaddr & LSB_MASK) != '0;
  assign w_ar_mis = (s_axi_araddr & LSB_MASK) != '0;
`else
  assign w_aw_mis = 1'b0;
  assign w_ar_mis = 1'b0;
`endif

  assign w_aw_hs = s_axi_awvalid & s_axi_awready;
  assign w_w_hs  = s_axi_wvalid & s_axi_wready;
  assign w_ar_hs = s_axi_arvalid & s_axi_arready;

  // ---------------- write path ----------------
  always_ff @(posedge clk or posedge rst)
    if (rst) r_wstate <= W_IDLE;
    else     r_wstate <= w_wnext;

  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_IDLE: begin
        if (w_aw_hs && w_w_hs) w_wnext = W_MEM;
        else if (w_aw_hs)      w_wnext = W_WAIT_W;
        else if (w_w_hs)       w_wnext = W_WAIT_AW;
      end
      W_WAIT_W:  if (w_w_hs)       w_wnext = W_MEM;
      W_WAIT_AW: if (w_aw_hs)      w_wnext = W_MEM;
      W_MEM:                       w_wnext = W_RESP;
      W_RESP:    if (s_axi_bready) w_wnext = W_IDLE;
      default:                     w_wnext = W_IDLE;
    endcase
  end

  // Readies stay low while reset is held even though the state already reads idle.
  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = 2'b00;
    mem_wr        = 1'b0;
    if (!rst) begin
      case (r_wstate)
        W_IDLE:    begin s_axi_awready = 1'b1; s_axi_wready = 1'b1; end
        W_WAIT_W:  s_axi_wready  = 1'b1;
        W_WAIT_AW: s_axi_awready = 1'b1;
        W_MEM:     mem_wr = ~r_wmis;
        W_RESP:    begin s_axi_bvalid = 1'b1; s_axi_bresp = r_wmis ? 2'b10 : 2'b00; end
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_waddr <= '0;
      r_wmis  <= 1'b0;
      r_wdata <= '0;
      r_wstrb <= '0;
    end else begin
      if (w_aw_hs) begin
        r_waddr <= s_axi_awaddr >> LSB;
        r_wmis  <= w_aw_mis;
      end
      if (w_w_hs) begin
        r_wdata <= s_axi_wdata;
        r_wstrb <= s_axi_wstrb;
      end
    end

  assign mem_wr_addr = r_waddr;
  assign mem_wr_data = r_wdata;
  assign mem_be      = r_wstrb;

  // ---------------- read path ----------------
  always_ff @(posedge clk or posedge rst)
    if (rst) r_rstate <= R_IDLE;
    else     r_rstate <= w_rnext;

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_IDLE:  if (w_ar_hs)      w_rnext = R_CAP;
      R_CAP:                     w_rnext = R_DATA;
      R_DATA:  if (s_axi_rready) w_rnext = R_IDLE;
      default:                   w_rnext = R_IDLE;
    endcase
  end

  // The RAM read is issued in the AR handshake cycle so its data lands in R_CAP.
  always_comb begin
    s_axi_arready = !rst && (r_rstate == R_IDLE);
    s_axi_rvalid  = (r_rstate == R_DATA);
    s_axi_rresp   = (s_axi_rvalid && r_rmis) ? 2'b10 : 2'b00;
    mem_rd        = w_ar_hs & ~w_ar_mis;
    mem_rd_addr   = s_axi_araddr >> LSB;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rmis  <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_ar_hs) r_rmis <= w_ar_mis;
      if (r_rstate == R_CAP) r_rdata <= r_rmis ? '0 : mem_rd_data;
    end

  assign s_axi_rdata = r_rdata;
  assign mem_cs      = mem_wr | mem_rd;

endmodule

// File: tb/tb_axi_ram_ctrl.sv
// tb_axi_ram_ctrl: directed plus random AXI4-Lite traffic against a word-array reference model.
// Honours `AXI_RAM_CTRL_SLVERR_EN when the DUT is built with it.
module tb_axi_ram_ctrl;
  localparam int DW = 32, AW = 8, SW = 4;

  logic          clk = 1'b0, rst = 1'b1, ram_clr = 1'b1;
  logic [AW-1:0] s_axi_awaddr, s_axi_araddr;
  logic          s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [DW-1:0] s_axi_wdata, s_axi_rdata;
  logic [SW-1:0] s_axi_wstrb;
  logic [1:0]    s_axi_bresp, s_axi_rresp;
  logic          s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic          s_axi_rvalid, s_axi_rready;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr;
  logic [DW-1:0] mem_wr_data, mem_rd_data;
  logic [SW-1:0] mem_be;
  logic          mem_wr, mem_rd, mem_cs;

  logic [DW-1:0] ram     [0:255];
  logic [DW-1:0] ref_mem [0:63];
  int n_vec = 0, n_err = 0;

  axi_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_be(mem_be), .mem_wr(mem_wr),
    .mem_rd_addr(mem_rd_addr), .mem_rd(mem_rd), .mem_rd_data(mem_rd_data), .mem_cs(mem_cs)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                               input logic [SW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // RAM macro: one-cycle read latency, garbage on the read port when not reading.
  always @(posedge clk) begin
    if (ram_clr) for (int i = 0; i < 256; i++) ram[i] <= '0;
    else if (mem_wr) ram[mem_wr_addr] <= byte_merge(ram[mem_wr_addr], mem_wr_data, mem_be);
    mem_rd_data <= mem_rd ? ram[mem_rd_addr] : DW'($urandom);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit misaligned(input logic [AW-1:0] a);
`ifdef AXI_RAM_CTRL_SLVERR_EN
    return a[1:0] != 2'b00;
`else
    return (a === 'x);
`endif
  endfunction

  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s,
                           input int aw_dly, input int w_dly);
    bit mis, aw_ok, w_ok, b_ok, hs_aw, hs_w, hs_b, prev_v;
    int cyc, t_aw, t_w, t_wr, t_b, n_wr, t_last;
    logic [1:0] resp;
    logic [DW-1:0] m;
    mis = misaligned(a);
    s_axi_awaddr = a; s_axi_wdata = d; s_axi_wstrb = s; s_axi_bready = 1'b0;
    s_axi_awvalid = (aw_dly == 0); s_axi_wvalid = (w_dly == 0);
    aw_ok = 0; w_ok = 0; b_ok = 0; prev_v = 0; resp = 2'bxx;
    cyc = 0; t_aw = -1; t_w = -1; t_wr = -1; t_b = -1; n_wr = 0;
    while (!b_ok && cyc < 60) begin
      @(negedge clk);
      hs_aw = s_axi_awvalid && s_axi_awready;
      hs_w  = s_axi_wvalid && s_axi_wready;
      hs_b  = s_axi_bvalid && s_axi_bready;
      if (mem_wr) begin
        n_wr++; t_wr = cyc;
        chk("wr_addr", mem_wr_addr, {2'b00, a[AW-1:2]});
        chk("wr_data", mem_wr_data, d);
        chk("wr_be", mem_be, s);
      end
      if (aw_ok && !w_ok) chk("aw_block", s_axi_awready, 0);
      if (w_ok && !aw_ok) chk("w_block", s_axi_wready, 0);
      if (prev_v) chk("bvalid_hold", s_axi_bvalid, 1);
      if (s_axi_bvalid && t_b < 0) t_b = cyc;
      if (hs_b) resp = s_axi_bresp;
      prev_v = s_axi_bvalid && !hs_b;
      @(posedge clk); #1;
      if (hs_aw) begin aw_ok = 1; t_aw = cyc; s_axi_awvalid = 1'b0; end
      if (hs_w)  begin w_ok = 1;  t_w = cyc;  s_axi_wvalid = 1'b0; end
      if (hs_b)  begin b_ok = 1;  s_axi_bready = 1'b0; end
      cyc++;
      if (!aw_ok && cyc >= aw_dly) s_axi_awvalid = 1'b1;
      if (!w_ok && cyc >= w_dly) s_axi_wvalid = 1'b1;
      if (!b_ok) s_axi_bready = 1'($urandom_range(0, 1));
    end
    t_last = (t_aw > t_w) ? t_aw : t_w;
    chk("b_done", b_ok, 1);
    chk("wr_count", n_wr, mis ? 0 : 1);
    if (!mis) chk("wr_lat", t_wr - t_last, 1);
    chk("b_lat", t_b - t_last, 2);
    chk("bresp", resp, mis ? 2'b10 : 2'b00);
    if (!mis) begin
      for (int b = 0; b < SW; b++) m[b*8 +: 8] = {8{s[b]}};
      ref_mem[a[AW-1:2]] = (ref_mem[a[AW-1:2]] & ~m) | (d & m);
    end
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input int r_dly);
    bit mis, r_ok, hs_ar, hs_r, prev_v;
    int cyc, t_ar, t_rv, n_rd;
    logic [DW-1:0] exp_d;
    mis = misaligned(a);
    exp_d = mis ? '0 : ref_mem[a[AW-1:2]];
    s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = (r_dly == 0);
    r_ok = 0; prev_v = 0; cyc = 0; t_ar = -1; t_rv = -1; n_rd = 0;
    while (!r_ok && cyc < 60) begin
      @(negedge clk);
      hs_ar = s_axi_arvalid && s_axi_arready;
      hs_r  = s_axi_rvalid && s_axi_rready;
      chk("rd_strobe", mem_rd, hs_ar && !mis);
      chk("cs", mem_cs, mem_wr | mem_rd);
      if (mem_rd) begin n_rd++; chk("rd_addr", mem_rd_addr, {2'b00, a[AW-1:2]}); end
      if (t_ar >= 0) chk("ar_block", s_axi_arready, 0);
      if (prev_v) chk("rvalid_hold", s_axi_rvalid, 1);
      if (s_axi_rvalid) begin
        if (t_rv < 0) t_rv = cyc;
        chk("rdata", s_axi_rdata, exp_d);
        chk("rresp", s_axi_rresp, mis ? 2'b10 : 2'b00);
      end
      prev_v = s_axi_rvalid && !hs_r;
      @(posedge clk); #1;
      if (hs_ar) begin t_ar = cyc; s_axi_arvalid = 1'b0; s_axi_araddr = AW'($urandom); end
      if (hs_r)  begin r_ok = 1; s_axi_rready = 1'b0; end
      cyc++;
      if (t_rv >= 0 && !r_ok && cyc - t_rv >= r_dly) s_axi_rready = 1'b1;
    end
    chk("r_done", r_ok, 1);
    chk("r_lat", t_rv - t_ar, 2);
    chk("rd_count", n_rd, mis ? 0 : 1);
  endtask

  initial begin
    logic [AW-1:0] a, ra;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    int ad, wd, rd;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
    s_axi_awaddr = '0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_araddr = '0;
    s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_arvalid = 1'b1;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", s_axi_awready, 0); chk("rst_wready", s_axi_wready, 0);
    chk("rst_arready", s_axi_arready, 0); chk("rst_bvalid", s_axi_bvalid, 0);
    chk("rst_rvalid", s_axi_rvalid, 0);   chk("rst_rdata", s_axi_rdata, 0);
    chk("rst_bresp", s_axi_bresp, 0);     chk("rst_rresp", s_axi_rresp, 0);
    chk("rst_mem_wr", mem_wr, 0);         chk("rst_mem_be", mem_be, 0);
    chk("rst_wr_addr", mem_wr_addr, 0);   chk("rst_wr_data", mem_wr_data, 0);
    chk("rst_mem_rd", mem_rd, 0);         chk("rst_mem_cs", mem_cs, 0);
    @(posedge clk); #1;
    rst = 1'b0; ram_clr = 1'b0;
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    @(negedge clk);
    chk("rel_awready", s_axi_awready, 1); chk("rel_wready", s_axi_wready, 1);
    chk("rel_arready", s_axi_arready, 1);
    @(posedge clk); #1;

    // same-cycle write and read of word 0x08: read sees the old value, next read the new one
    fork
      axi_write(8'h20, 32'h0000_0005, 4'hF, 0, 0);
      axi_read(8'h20, 0);
    join
    axi_read(8'h20, 0);

    axi_write(8'h10, 32'hDEAD_BEEF, 4'hF, 0, 0);
    axi_read(8'h10, 0);
    axi_write(8'h20, 32'h1122_3344, 4'hF, 0, 0);
    axi_write(8'h20, 32'hAABB_CCDD, 4'b0101, 0, 0);
    axi_read(8'h20, 1);
    axi_write(8'h14, 32'hCAFE_F00D, 4'hF, 0, 3);   // AW leads W by 3 cycles
    axi_write(8'h18, 32'h0BAD_CAFE, 4'hC, 2, 0);   // W leads AW
    axi_read(8'h14, 4);                             // rready held low 4 cycles
    axi_read(8'h18, 2);

    // reset while the read sits in the capture cycle
    s_axi_araddr = 8'h10; s_axi_arvalid = 1'b1;
    @(negedge clk); chk("rr_arready", s_axi_arready, 1);
    @(posedge clk); #1;
    s_axi_arvalid = 1'b1; rst = 1'b1;
    @(negedge clk);
    chk("rr_rvalid", s_axi_rvalid, 0); chk("rr_arready0", s_axi_arready, 0);
    chk("rr_mem_rd", mem_rd, 0);       chk("rr_mem_cs", mem_cs, 0);
    chk("rr_rdata", s_axi_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0; s_axi_arvalid = 1'b0;
    @(negedge clk); chk("rr_arready1", s_axi_arready, 1);
    for (int i = 0; i < 4; i++) begin @(negedge clk); chk("rr_no_beat", s_axi_rvalid, 0); end
    @(posedge clk); #1;

`ifdef AXI_RAM_CTRL_SLVERR_EN
    axi_read(8'h13, 0);
    axi_write(8'h11, 32'h1234_5678, 4'hF, 0, 0);
    axi_read(8'h10, 0);
`endif

    for (int i = 0; i < 30; i++) begin
      a = AW'($urandom_range(0, 31)); ra = ($urandom_range(0, 1) == 1) ? a : AW'($urandom_range(0, 31));
      d = $urandom; s = SW'($urandom);
      ad = $urandom_range(0, 3); wd = $urandom_range(0, 3); rd = $urandom_range(0, 4);
      case ($urandom_range(0, 2))
        0: axi_write(a, d, s, ad, wd);
        1: axi_read(ra, rd);
        default: fork
          axi_write(a, d, s, ad, wd);
          axi_read(ra, rd);
        join
      endcase
    end
    for (int w = 0; w < 8; w++) axi_read(AW'(w * 4), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
